// File: rtl/nco_sweep_pkg.sv
// Shared definitions for the NCO sweep controller: sweep states and default widths
// (INC_W must track the NCO phase-increment input).
package nco_sweep_pkg;

  localparam int INC_W_DEF   = 8;
  localparam int DIV_W_DEF   = 25;
  localparam int DWELL_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_e;

endpackage

// File: rtl/nco_sweep_strobe_div.sv
// Prescaler: counts 0..div and wraps; strobe marks the first cycle of each
// period, wrap marks the last. Held at zero while clr is high.
module strobe_div
  import nco_sweep_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             pll_clock,
  input  logic             reset_n,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             strobe,
  output logic             wrap
);

  logic [DIV_W-1:0] count;

  always_ff @(posedge pll_clock or negedge reset_n) begin
    if (!reset_n)                count <= '0;
    else if (clr || count >= div) count <= '0;
    else                          count <= count + 1'b1;
  end

  assign strobe = (count == '0);
  assign wrap   = (count >= div);

endmodule

// File: rtl/nco_sweep.sv
// Stepped-chirp controller feeding the NCO phase increment and clock enable.
// One-shot sawtooth or continuous triangle between two latched increments.
module nco_sweep
  import nco_sweep_pkg::*;
#(
  parameter int INC_W   = INC_W_DEF,
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               pll_clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [INC_W-1:0]   cfg_lo,
  input  logic [INC_W-1:0]   cfg_hi,
  input  logic [INC_W-1:0]   cfg_step,
  input  logic [DIV_W-1:0]   cfg_div,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_triangle,
  output logic               nco_en,
  output logic [INC_W-1:0]   phase_inc,
  output logic               busy,
  output logic               done
);

  typedef struct packed {
    logic [INC_W-1:0]   lo;
    logic [INC_W-1:0]   hi;
    logic [INC_W-1:0]   step;
    logic [DIV_W-1:0]   div;
    logic [DWELL_W-1:0] dwell;
    logic               triangle;
  } cfg_t;

  state_e             state, state_d;
  cfg_t               cfg_s;
  logic [DWELL_W-1:0] dwell_cnt, dwell_d;
  logic [INC_W-1:0]   phase_d, up_v, dn_v;
  logic [INC_W:0]     sum, diff;
  logic               done_d, load, strobe, wrap, running;

  assign running = (state != IDLE);

  strobe_div #(.DIV_W(DIV_W)) u_div (
    .pll_clock (pll_clock),
    .reset_n   (reset_n),
    .clr       (!running),
    .div       (cfg_s.div),
    .strobe    (strobe),
    .wrap      (wrap)
  );

  // Saturating neighbours of the current increment. The up value is also
  // floored at lo so an inverted range (lo > hi) holds a steady tone at lo.
  always_comb begin
    sum  = {1'b0, phase_inc} + {1'b0, cfg_s.step};
    diff = {1'b0, phase_inc} - {1'b0, cfg_s.step};
    up_v = (sum > {1'b0, cfg_s.hi}) ? cfg_s.hi : sum[INC_W-1:0];
    if (up_v < cfg_s.lo) up_v = cfg_s.lo;
    dn_v = (diff[INC_W] || diff[INC_W-1:0] < cfg_s.lo) ? cfg_s.lo : diff[INC_W-1:0];
  end

  // Dwell advances on the last cycle of each strobe period, so a new value
  // lands on the next prescale==0 cycle and is held (dwell+1)*(div+1) cycles.
  always_comb begin
    state_d = state;
    phase_d = phase_inc;
    dwell_d = dwell_cnt;
    done_d  = 1'b0;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          load    = 1'b1;
          phase_d = cfg_lo;
          dwell_d = '0;
          state_d = UP;
        end
      end
      default: begin
        if (abort) begin
          state_d = IDLE;
        end else if (wrap) begin
          if (dwell_cnt == cfg_s.dwell) begin
            dwell_d = '0;
            if (state == UP) begin
              if (phase_inc >= cfg_s.hi) begin
                if (cfg_s.triangle) begin
                  state_d = DOWN;
                  phase_d = dn_v;
                end else begin
                  state_d = IDLE;
                  done_d  = 1'b1;
                end
              end else begin
                phase_d = up_v;
              end
            end else begin
              if (phase_inc <= cfg_s.lo) begin
                state_d = UP;
                phase_d = up_v;
              end else begin
                phase_d = dn_v;
              end
            end
          end else begin
            dwell_d = dwell_cnt + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge pll_clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      phase_inc <= '0;
      dwell_cnt <= '0;
      done      <= 1'b0;
      cfg_s     <= '0;
    end else begin
      state     <= state_d;
      phase_inc <= phase_d;
      dwell_cnt <= dwell_d;
      done      <= done_d;
      if (load) begin
        cfg_s.lo       <= cfg_lo;
        cfg_s.hi       <= cfg_hi;
        cfg_s.step     <= (cfg_step == '0) ? {{(INC_W-1){1'b0}}, 1'b1} : cfg_step;
        cfg_s.div      <= cfg_div;
        cfg_s.dwell    <= cfg_dwell;
        cfg_s.triangle <= cfg_triangle;
      end
    end
  end

  assign busy   = running;
  assign nco_en = running && strobe;

endmodule

// File: tb/tb_nco_sweep.sv
// Table-driven sweep vectors with a per-cycle scoreboard, plus hand sequences
// for start/abort priority, ignored mid-sweep inputs and async reset.
module tb_nco_sweep;

  logic        pll_clock = 1'b0;
  logic        reset_n   = 1'b1;
  logic        start = 1'b0, abort = 1'b0, cfg_triangle = 1'b0;
  logic [7:0]  cfg_lo = '0, cfg_hi = '0, cfg_step = '0;
  logic [24:0] cfg_div = '0;
  logic [15:0] cfg_dwell = '0;
  logic        nco_en, busy, done;
  logic [7:0]  phase_inc;

  nco_sweep dut (
    .pll_clock    (pll_clock),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .cfg_lo       (cfg_lo),
    .cfg_hi       (cfg_hi),
    .cfg_step     (cfg_step),
    .cfg_div      (cfg_div),
    .cfg_dwell    (cfg_dwell),
    .cfg_triangle (cfg_triangle),
    .nco_en       (nco_en),
    .phase_inc    (phase_inc),
    .busy         (busy),
    .done         (done)
  );

  always #5 pll_clock = ~pll_clock;

  // seq holds the expected increment values, first in the low byte; each is
  // held 'hold' cycles and the last one persists. Masks are per cycle k after start.
  typedef struct packed {
    logic [7:0]  lo, hi, step;
    logic [24:0] div;
    logic [15:0] dwell;
    logic        tri_m;
    logic [63:0] seq;
    logic [7:0]  nvals, hold;
    logic [47:0] en, bz, dn;
  } vec_t;

  typedef struct {
    logic [7:0] ph;
    logic       en, bz, dn;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];
  int   checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic set_cfg(input logic [7:0] lo, hi, step, input logic [24:0] dv,
                         input logic [15:0] dw, input logic tm);
    cfg_lo = lo; cfg_hi = hi; cfg_step = step;
    cfg_div = dv; cfg_dwell = dw; cfg_triangle = tm;
  endtask

  // Called at a falling edge; start is sampled by the next rising edge.
  task automatic run_vec(input vec_t v, input int id);
    exp_t e;
    int   idx;
    set_cfg(v.lo, v.hi, v.step, v.div, v.dwell, v.tri_m);
    start = 1'b1;
    @(negedge pll_clock);
    start = 1'b0;
    for (int k = 0; k <= 48; k++) begin
      idx = k / int'(v.hold);
      if (idx >= int'(v.nvals)) idx = int'(v.nvals) - 1;
      e.ph = v.seq[8*idx +: 8];
      e.en = (k < 48) ? v.en[k] : 1'b0;
      e.bz = (k < 48) ? v.bz[k] : 1'b0;
      e.dn = (k < 48) ? v.dn[k] : 1'b0;
      sb.push_back(e);
    end
    for (int k = 0; k < 48; k++) begin
      e = sb.pop_front();
      chk($sformatf("v%0d_phase_k%0d", id, k), 32'(phase_inc), 32'(e.ph));
      chk($sformatf("v%0d_nco_en_k%0d", id, k), 32'(nco_en), 32'(e.en));
      chk($sformatf("v%0d_busy_k%0d", id, k), 32'(busy), 32'(e.bz));
      chk($sformatf("v%0d_done_k%0d", id, k), 32'(done), 32'(e.dn));
      @(negedge pll_clock);
    end
    e = sb.pop_front();
    chk($sformatf("v%0d_phase_k48", id), 32'(phase_inc), 32'(e.ph));
    abort = 1'b1;
    @(negedge pll_clock);
    abort = 1'b0;
    chk($sformatf("v%0d_abort_busy", id), 32'(busy), 32'd0);
    chk($sformatf("v%0d_abort_en", id), 32'(nco_en), 32'd0);
    chk($sformatf("v%0d_abort_done", id), 32'(done), 32'd0);
    chk($sformatf("v%0d_abort_phase", id), 32'(phase_inc), 32'(e.ph));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'd2, 8'd6, 8'd2, 25'd0, 16'd0, 1'b0, 64'h060402, 8'd3, 8'd1,
                48'h7, 48'h7, 48'h8};
    vecs[1] = '{8'd250, 8'd255, 8'd10, 25'd0, 16'd0, 1'b0, 64'hFFFA, 8'd2, 8'd1,
                48'h3, 48'h3, 48'h4};
    vecs[2] = '{8'd10, 8'd12, 8'd1, 25'd3, 16'd1, 1'b1, 64'h0C0B0A0B0C0B0A, 8'd7, 8'd8,
                48'h111111111111, 48'hFFFFFFFFFFFF, 48'h0};
    vecs[3] = '{8'd7, 8'd7, 8'd1, 25'd1, 16'd0, 1'b1, 64'h07, 8'd1, 8'd1,
                48'h555555555555, 48'hFFFFFFFFFFFF, 48'h0};
    vecs[4] = '{8'd9, 8'd5, 8'd3, 25'd1, 16'd1, 1'b0, 64'h09, 8'd1, 8'd1,
                48'h5, 48'hF, 48'h10};
    vecs[5] = '{8'd20, 8'd22, 8'd0, 25'd0, 16'd0, 1'b0, 64'h161514, 8'd3, 8'd1,
                48'h7, 48'h7, 48'h8};

    #1 reset_n = 1'b0;
    #2;
    chk("reset_phase", 32'(phase_inc), 32'd0);
    chk("reset_en", 32'(nco_en), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    @(negedge pll_clock);
    reset_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // start and abort together in IDLE: abort wins, phase keeps 22
    set_cfg(8'd50, 8'd60, 8'd1, 25'd0, 16'd0, 1'b0);
    start = 1'b1; abort = 1'b1;
    @(negedge pll_clock);
    start = 1'b0; abort = 1'b0;
    chk("prio_busy", 32'(busy), 32'd0);
    chk("prio_en", 32'(nco_en), 32'd0);
    chk("prio_phase", 32'(phase_inc), 32'd22);

    // start and cfg changes mid-sweep are ignored
    set_cfg(8'd1, 8'd4, 8'd1, 25'd0, 16'd0, 1'b0);
    start = 1'b1;
    @(negedge pll_clock);
    chk("mid_k0_phase", 32'(phase_inc), 32'd1);
    cfg_lo = 8'd100; cfg_hi = 8'd200;
    @(negedge pll_clock);
    start = 1'b0;
    chk("mid_k1_phase", 32'(phase_inc), 32'd2);
    @(negedge pll_clock);
    chk("mid_k2_phase", 32'(phase_inc), 32'd3);
    @(negedge pll_clock);
    chk("mid_k3_phase", 32'(phase_inc), 32'd4);
    chk("mid_k3_busy", 32'(busy), 32'd1);
    @(negedge pll_clock);
    chk("mid_k4_done", 32'(done), 32'd1);
    chk("mid_k4_busy", 32'(busy), 32'd0);
    chk("mid_k4_phase", 32'(phase_inc), 32'd4);
    @(negedge pll_clock);
    chk("mid_k5_done", 32'(done), 32'd0);

    // asynchronous reset in UP, then a clean restart
    set_cfg(8'd2, 8'd6, 8'd2, 25'd0, 16'd0, 1'b0);
    start = 1'b1;
    @(negedge pll_clock);
    start = 1'b0;
    @(negedge pll_clock);
    chk("rst_pre_phase", 32'(phase_inc), 32'd4);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_phase", 32'(phase_inc), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_en", 32'(nco_en), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge pll_clock);
    reset_n = 1'b1;
    set_cfg(8'd3, 8'd5, 8'd1, 25'd0, 16'd0, 1'b0);
    start = 1'b1;
    @(negedge pll_clock);
    start = 1'b0;
    chk("restart_phase", 32'(phase_inc), 32'd3);
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_en", 32'(nco_en), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
